// File: rtl/numberle_pkg.sv
// Shared definitions for the numberle game blocks: keypad codes, guess width
// and the guess-entry FSM states.
package numberle_pkg;

   localparam int DIGITS = 4;

   localparam logic [3:0] KEY_BACK  = 4'hA;
   localparam logic [3:0] KEY_CLEAR = 4'hB;
   localparam logic [3:0] KEY_ENTER = 4'hF;

   typedef enum logic [1:0] {
      ENTRY  = 2'd0,
      SUBMIT = 2'd1,
      LOCKED = 2'd2
   } state_e;

endpackage

// File: rtl/key_decoder.sv
// Classifies a keypad code; codes 0xC-0xE assert nothing and are thereby ignored.
module key_decoder
   import numberle_pkg::*;
(
   input  logic [3:0] key_code,
   output logic       is_digit,
   output logic       is_back,
   output logic       is_clear,
   output logic       is_enter
);

   assign is_digit = (key_code <= 4'h9);
   assign is_back  = (key_code == KEY_BACK);
   assign is_clear = (key_code == KEY_CLEAR);
   assign is_enter = (key_code == KEY_ENTER);

endmodule

// File: rtl/guess_entry.sv
// Keypad guess entry for the numberle game: builds a four-digit BCD guess,
// submits it on enter and locks the game once solved or out of tries.
module guess_entry
   import numberle_pkg::*;
#(
   parameter int MAX_TRIES = 4
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        solved,
   input  logic        new_game,
   output logic [15:0] entry,
   output logic [2:0]  count,
   output logic [15:0] guess,
   output logic        submit,
   output logic [3:0]  try,
   output logic        locked
);

   localparam logic [3:0] TRY_MAX = 4'(MAX_TRIES);
   localparam logic [2:0] CNT_MAX = 3'(DIGITS);

   state_e      state_q, state_d;
   logic [15:0] entry_q, entry_d;
   logic [2:0]  count_q, count_d;
   logic [15:0] guess_q, guess_d;
   logic        submit_q, submit_d;
   logic [3:0]  try_q, try_d;
   logic        locked_q, locked_d;

   logic is_digit, is_back, is_clear, is_enter;

   key_decoder u_key_decoder (
      .key_code (key_code),
      .is_digit (is_digit),
      .is_back  (is_back),
      .is_clear (is_clear),
      .is_enter (is_enter)
   );

   always_comb begin
      state_d  = state_q;
      entry_d  = entry_q;
      count_d  = count_q;
      guess_d  = guess_q;
      submit_d = 1'b0;
      try_d    = try_q;
      locked_d = locked_q;

      if (new_game) begin
         state_d  = ENTRY;
         entry_d  = '0;
         count_d  = '0;
         guess_d  = '0;
         try_d    = '0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            ENTRY: begin
               if (key_valid) begin
                  if (is_digit && count_q < CNT_MAX) begin
                     // First digit lands in the most significant nibble.
                     for (int i = 0; i < DIGITS; i++)
                        if (count_q == 3'(i))
                           entry_d[4*(DIGITS-1-i) +: 4] = key_code;
                     count_d = count_q + 3'd1;
                  end else if (is_back && count_q != 3'd0) begin
                     for (int i = 0; i < DIGITS; i++)
                        if (count_q == 3'(i + 1))
                           entry_d[4*(DIGITS-1-i) +: 4] = 4'h0;
                     count_d = count_q - 3'd1;
                  end else if (is_clear) begin
                     entry_d = '0;
                     count_d = '0;
                  end else if (is_enter && count_q == CNT_MAX && try_q < TRY_MAX) begin
                     state_d  = SUBMIT;
                     guess_d  = entry_q;
                     try_d    = try_q + 4'd1;
                     submit_d = 1'b1;
                     entry_d  = '0;
                     count_d  = '0;
                  end
               end
            end
            SUBMIT: begin
               // try_q already counts this guess, so equality means no tries remain.
               if (solved || try_q == TRY_MAX) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
               end else begin
                  state_d = ENTRY;
               end
            end
            LOCKED: ;
            default: state_d = ENTRY;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q  <= ENTRY;
         entry_q  <= '0;
         count_q  <= '0;
         guess_q  <= '0;
         submit_q <= 1'b0;
         try_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         entry_q  <= entry_d;
         count_q  <= count_d;
         guess_q  <= guess_d;
         submit_q <= submit_d;
         try_q    <= try_d;
         locked_q <= locked_d;
      end
   end

   assign entry  = entry_q;
   assign count  = count_q;
   assign guess  = guess_q;
   assign submit = submit_q;
   assign try    = try_q;
   assign locked = locked_q;

endmodule

// File: doc/guess_entry.md
GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 SHALL provide parameter MAX_TRIES, default 4, maximum number of guesses per game (1-15).
REQ-002 SHALL provide port clock  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL provide port resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL provide port key_valid  input  1  one-cycle strobe, debounced keypad press.
REQ-005 SHALL provide port key_code  input  4  code of pressed key, sampled when key_valid=1.
REQ-006 SHALL provide port solved  input  1  level from game logic; guess matched the secret.
REQ-007 SHALL provide port new_game  input  1  one-cycle strobe; restart game.
REQ-008 SHALL provide port entry  output  16  in-progress guess, four BCD nibbles, for display.
REQ-009 SHALL provide port count  output  3  digits currently entered, 0-4.
REQ-010 SHALL provide port guess  output  16  last submitted guess, stable between submits.
REQ-011 SHALL provide port submit  output  1  one-cycle pulse; guess/try just updated.
REQ-012 SHALL provide port try  output  4  number of guesses submitted this game, 0..MAX_TRIES.
REQ-013 SHALL provide port locked  output  1  game over (solved or tries exhausted); entry disabled.

Function
REQ-014 Key codes SHALL be: 0x0-0x9 digit, 0xA backspace, 0xB clear, 0xF enter; 0xC-0xE ignored.
REQ-015 FSM states SHALL be ENTRY, SUBMIT, LOCKED.
REQ-016 ENTRY, digit, count<4: digit written to entry nibble [15-4*count -: 4] (first digit in [15:12]), count+1, next cycle.
REQ-017 ENTRY, digit, count=4: ignored, no state change.
REQ-018 ENTRY, backspace, count>0: count-1, vacated nibble zeroed; count=0: ignored.
REQ-019 ENTRY, clear: entry=0, count=0.
REQ-020 ENTRY, enter, count<4: ignored.
REQ-021 ENTRY, enter, count=4: next cycle state=SUBMIT, guess=entry, try=try+1, submit=1, entry=0, count=0.
REQ-022 SUBMIT lasts exactly one cycle; key_valid during SUBMIT dropped.
REQ-023 SUBMIT exit: solved=1 or try=MAX_TRIES -> LOCKED; else -> ENTRY.
REQ-024 solved SHALL be sampled only in SUBMIT (game logic combinational, valid same cycle as submit).
REQ-025 LOCKED: locked=1; all keys ignored; guess and try held.
REQ-026 new_game in any state: next cycle entry=0, count=0, guess=0, try=0, submit=0, state=ENTRY.
REQ-027 new_game and key_valid same cycle: new_game wins, key dropped.
REQ-028 submit SHALL be high only in SUBMIT; never two consecutive cycles.
REQ-029 try SHALL never exceed MAX_TRIES and never wrap.
REQ-030 All outputs registered; no combinational input-to-output path.

Reset
REQ-031 resetn=0 at a rising edge: state=ENTRY, entry=0, count=0, guess=0, try=0, submit=0, locked=0.
REQ-032 Reset mid-SUBMIT or LOCKED SHALL behave identically to REQ-031; reset overrides new_game and key_valid.

Structure
REQ-033 Shared package numberle_pkg SHALL hold key-code constants (KEY_BACK, KEY_CLEAR, KEY_ENTER), FSM state enum, DIGITS=4.
REQ-034 One sub-module key_decoder (combinational: key_code -> is_digit/is_back/is_clear/is_enter) SHALL be instantiated; all else in guess_entry.

Verification
REQ-035 Keys 1,2,3,4,F -> entry 0x1234 before F; one cycle after F: submit=1, guess=0x1234, try=1, count=0, entry=0.
REQ-036 Keys 5,6,A,7,8,9 -> entry 0x5789, count=4; extra digit 3 ignored; F with count=3 ignored (no submit).
REQ-037 Four full guesses, solved=0 -> try=4, locked=1 after 4th SUBMIT; further keys no effect; new_game -> try=0, locked=0.
REQ-038 Guess 0x4321 submitted with solved=1 in SUBMIT, try=2 -> LOCKED, try stays 2, guess stays 0x4321.
REQ-039 new_game and key_valid(digit 7) same cycle -> entry=0, count=0; resetn=0 during SUBMIT -> all outputs zero next cycle.
